// File: rtl/ariane_pkg.sv
// ariane_pkg: CFI log entry type and the log arbiter state encoding
package ariane_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  kind;
  } cfi_log_t;
  typedef enum logic [1:0] {IDLE, XFER, WAIT_CMPL} cfi_arb_state_e;
endpackage

// File: rtl/cfi_arb_rr_pick.sv
// cfi_arb_rr_pick: first set request at or above rr_ptr, wrapping at NR_HARTS
module cfi_arb_rr_pick #(
  parameter int NR_HARTS = 2,
  localparam int IdW = NR_HARTS > 1 ? $clog2(NR_HARTS) : 1
) (
  input  logic [NR_HARTS-1:0] req,
  input  logic [IdW-1:0]      rr_ptr,
  output logic [IdW-1:0]      gnt_idx,
  output logic                gnt_valid
);
  function automatic int wrap(input int v);
    return v >= NR_HARTS ? v - NR_HARTS : v;
  endfunction
  always_comb begin
    gnt_idx = '0;
    gnt_valid = 1'b0;
    for (int i = NR_HARTS - 1; i >= 0; i--) begin
      if (req[wrap(int'(rr_ptr) + i)]) begin
        gnt_idx = IdW'(wrap(int'(rr_ptr) + i));
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cfi_log_arbiter.sv
// cfi_log_arbiter: round-robin share of one CFI mailbox backend across harts; CFI_ARB_TIMEOUT_EN adds a completion timeout
module cfi_log_arbiter
  import ariane_pkg::*;
#(
  parameter int NR_HARTS = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IdW = NR_HARTS > 1 ? $clog2(NR_HARTS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  cfi_log_t [NR_HARTS-1:0]  log_i,
  input  logic [NR_HARTS-1:0]      log_valid_i,
  output logic [NR_HARTS-1:0]      log_pop_o,
  output cfi_log_t                 bk_log_o,
  output logic                     bk_valid_o,
  input  logic                     bk_ready_i,
  input  logic                     mbox_completion_irq_i,
  output logic [IdW-1:0]           grant_id_o,
  output logic                     busy_o,
  output logic                     err_timeout_o
);
  cfi_arb_state_e state_q, state_d;
  logic [IdW-1:0] rr_ptr, grant_q, pick_idx;
  logic pick_valid, hs, done, tmo;
  cfi_arb_rr_pick #(.NR_HARTS(NR_HARTS)) u_pick (
    .req(log_valid_i),
    .rr_ptr(rr_ptr),
    .gnt_idx(pick_idx),
    .gnt_valid(pick_valid)
  );
  assign hs = state_q == XFER && bk_ready_i;
  assign done = (hs && mbox_completion_irq_i) ||
                (state_q == WAIT_CMPL && (mbox_completion_irq_i || tmo));
`ifdef CFI_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt;
  assign tmo = state_q == WAIT_CMPL && !mbox_completion_irq_i && tmo_cnt == CntW'(TIMEOUT_CYCLES);
  assign err_timeout_o = tmo;
  always_ff @(posedge clk_i) begin
    tmo_cnt <= (rst_i || state_q != WAIT_CMPL || done) ? '0 : tmo_cnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
  assign err_timeout_o = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_ptr <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_valid) grant_q <= pick_idx;
      if (done) rr_ptr <= grant_q == IdW'(NR_HARTS - 1) ? '0 : grant_q + 1'b1;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (pick_valid ? XFER : IDLE) :
              state_q == XFER ? (done ? IDLE : hs ? WAIT_CMPL : XFER) :
              (done ? IDLE : WAIT_CMPL);
  end
  always_comb begin
    bk_valid_o = state_q == XFER;
    bk_log_o = log_i[grant_q];
    log_pop_o = hs ? NR_HARTS'(1) << grant_q : '0;
    busy_o = state_q != IDLE;
    grant_id_o = grant_q;
  end
endmodule

// File: tb/tb_cfi_log_arbiter.sv
// tb_cfi_log_arbiter: scoreboard bench with a queue-level round-robin model
module tb_cfi_log_arbiter;
  import ariane_pkg::*;
  localparam int N = 3;
  localparam int T = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cfi_log_t [N-1:0] log_i = '0;
  logic [N-1:0] log_valid = '0;
  logic [N-1:0] log_pop;
  cfi_log_t bk_log;
  logic bk_valid, bk_ready, irq, busy, err;
  logic [1:0] gid;
  typedef struct {
    int hart;
    cfi_log_t log;
  } exp_t;
  exp_t exp_q[$];
  exp_t me;
  cfi_log_t hq[N][$];
  cfi_log_t mq[N][$];
  cfi_log_t last_e;
  int m_ptr = 0;
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int pop_t[$];
  logic [N-1:0] ps;
  bit prev;

  always #5 clk = ~clk;

  cfi_log_arbiter #(.NR_HARTS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .log_i(log_i),
    .log_valid_i(log_valid),
    .log_pop_o(log_pop),
    .bk_log_o(bk_log),
    .bk_valid_o(bk_valid),
    .bk_ready_i(bk_ready),
    .mbox_completion_irq_i(irq),
    .grant_id_o(gid),
    .busy_o(busy),
    .err_timeout_o(err)
  );

  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic load(input int c0, input int c1, input int c2);
    int c[N];
    int h;
    cfi_log_t e;
    exp_t x;
    c[0] = c0;
    c[1] = c1;
    c[2] = c2;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < c[k]; j++) begin
        e = {$urandom, $urandom, 2'($urandom)};
        hq[k].push_back(e);
        mq[k].push_back(e);
        last_e = e;
      end
    while (mq[0].size() + mq[1].size() + mq[2].size() > 0) begin
      h = m_ptr;
      while (mq[h].size() == 0) h = (h + 1) % N;
      x.hart = h;
      x.log = mq[h].pop_front();
      exp_q.push_back(x);
      m_ptr = (h + 1) % N;
    end
  endtask

  task automatic drain(input int lim, input bit rnd);
    int k;
    k = 0;
    do begin
      step();
      if (rnd) begin
        bk_ready = 1'($urandom);
        irq = $urandom_range(2) == 0;
      end
      @(negedge clk);
      k++;
    end while ((exp_q.size() != 0 || busy) && k < lim);
    chk("drain_done", exp_q.size() == 0 && !busy, 1);
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always begin
    @(negedge clk);
    ps = log_pop;
    @(posedge clk);
    #1;
    for (int h = 0; h < N; h++)
      if (ps[h] && hq[h].size() > 0) void'(hq[h].pop_front());
    for (int h = 0; h < N; h++) begin
      log_valid[h] = hq[h].size() != 0;
      log_i[h] = hq[h].size() != 0 ? hq[h][0] : '0;
    end
  end

  always @(negedge clk) begin
    if (!rst && log_pop != '0) begin
      pop_t.push_back(cyc_n);
      if (exp_q.size() == 0) chk("unexpected_pop", log_pop, '0);
      else begin
        me = exp_q.pop_front();
        chk("pop_id", gid, me.hart);
        chk("pop_log", bk_log, me.log);
        chk("pop_onehot", log_pop, 1 << me.hart);
        chk("pop_valid", bk_valid, 1);
      end
    end
  end

  initial begin
    bk_ready = 1'b1;
    irq = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", bk_valid, 0);
    chk("rst_pop", log_pop, 0);
    chk("rst_gid", gid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    load(1, 0, 0);
    step();
    @(negedge clk);
    chk("lat_before", bk_valid, 0);
    step();
    @(negedge clk);
    chk("lat_valid", bk_valid, 1);
    chk("single_pop", log_pop, 3'b001);
    chk("single_gid", gid, 0);
    chk("single_busy", busy, 1);
    step();
    @(negedge clk);
    chk("pop_one_cycle", log_pop, 0);
    chk("wait_busy", busy, 1);
    step();
    step();
    irq = 1'b1;
    @(negedge clk);
    chk("busy_irq_cycle", busy, 1);
    step();
    irq = 1'b0;
    @(negedge clk);
    chk("busy_after_irq", busy, 0);
    chk("gid_kept", gid, 0);
    do_reset();
    irq = 1'b1;
    pop_t.delete();
    load(2, 2, 1);
    prev = 1'b0;
    repeat (14) begin
      step();
      @(negedge clk);
      if (prev) chk("idle_after_cmpl", busy, 0);
      prev = log_pop != '0;
    end
    chk("rr_pop_count", pop_t.size(), 5);
    for (int i = 1; i < 5 && i < pop_t.size(); i++) chk("rr_gap", pop_t[i] - pop_t[i-1], 2);
    chk("rr_all_seen", exp_q.size(), 0);
    load(0, 1, 0);
    repeat (4) begin
      step();
      @(negedge clk);
    end
    load(1, 1, 1);
    repeat (8) begin
      step();
      @(negedge clk);
    end
    chk("wrap_all_seen", exp_q.size(), 0);
    irq = 1'b0;
    bk_ready = 1'b0;
    load(0, 0, 1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      irq = i == 2;
      @(negedge clk);
      chk("hold_valid", bk_valid, 1);
      chk("hold_log", bk_log, last_e);
      chk("hold_gid", gid, 2);
      chk("hold_nopop", log_pop, 0);
      step();
    end
    bk_ready = 1'b1;
    @(negedge clk);
    chk("ready_pop", log_pop, 3'b100);
    step();
    @(negedge clk);
    chk("irq_ignored_wait", busy, 1);
    step();
    irq = 1'b1;
    step();
    irq = 1'b0;
    @(negedge clk);
    chk("hold_done", busy, 0);
    load(1, 0, 0);
    step();
    step();
    step();
    @(negedge clk);
    chk("in_wait", busy, 1);
`ifndef CFI_ARB_TIMEOUT_EN
    repeat (12) step();
    @(negedge clk);
    chk("wait_forever", busy, 1);
    chk("no_err", err, 0);
`endif
    do_reset();
    @(negedge clk);
    chk("mid_rst_valid", bk_valid, 0);
    chk("mid_rst_pop", log_pop, 0);
    chk("mid_rst_gid", gid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    irq = 1'b1;
    load(1, 1, 0);
    drain(40, 1'b0);
`ifdef CFI_ARB_TIMEOUT_EN
    irq = 1'b0;
    load(0, 0, 1);
    step();
    step();
    for (int i = 0; i < T; i++) begin
      step();
      @(negedge clk);
      chk("tmo_early", err, 0);
    end
    step();
    @(negedge clk);
    chk("tmo_pulse", err, 1);
    step();
    @(negedge clk);
    chk("tmo_idle", busy, 0);
    chk("tmo_single", err, 0);
    irq = 1'b1;
    load(1, 0, 0);
    drain(40, 1'b0);
`endif
    repeat (20) begin
      load($urandom_range(3), $urandom_range(3), $urandom_range(3));
      drain(400, 1'b1);
    end
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
